arb_xfer_ctrl: RTL

ARB_XFER_CTRL -- requirements
Module: arb_xfer_ctrl

---
 rtl/arb_xfer_pkg.sv | 6 +
 rtl/arb_xfer_ctrl_if.sv | 17 +
 rtl/arb_xfer_ctrl_onehot_enc.sv | 18 +
 rtl/arb_xfer_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/arb_xfer_pkg.sv
// arb_xfer_pkg: shared client count, client id type and controller state encoding
package arb_xfer_pkg;
  localparam int NUM_CLIENTS = 4;
  typedef logic [1:0] client_id_t;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/arb_xfer_ctrl_if.sv
// arb_xfer_ctrl_if: beat stream toward the sink; carries out_par only when ARB_XFER_PARITY_EN is defined
interface arb_xfer_ctrl_if #(parameter int DATA_W = 8);
  import arb_xfer_pkg::*;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [DATA_W-1:0] out_data;
  client_id_t out_id;
`ifdef ARB_XFER_PARITY_EN
  logic out_par;
  modport master(output out_valid, out_data, out_id, out_last, out_par, input out_ready);
  modport slave(input out_valid, out_data, out_id, out_last, out_par, output out_ready);
`else
  modport master(output out_valid, out_data, out_id, out_last, input out_ready);
  modport slave(input out_valid, out_data, out_id, out_last, output out_ready);
`endif
endinterface

// File: rtl/arb_xfer_ctrl_onehot_enc.sv
// onehot_enc: 4 grant lines to 2-bit id with exactly-one and two-or-more flags
module onehot_enc
  import arb_xfer_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] grant,
  output client_id_t             id,
  output logic                   valid,
  output logic                   multi
);
  logic [2:0] n;
  // population count drives both flags; id is meaningful only when valid
  always_comb begin
    n = 3'(grant[0]) + 3'(grant[1]) + 3'(grant[2]) + 3'(grant[3]);
    valid = n == 3'd1;
    multi = n >= 3'd2;
    id = grant[3] ? 2'd3 : grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
  end
endmodule

// File: rtl/arb_xfer_ctrl.sv
// arb_xfer_ctrl: latches a one-hot grant and streams BURST_LEN beats from that client; ARB_XFER_PARITY_EN adds out_par
module arb_xfer_ctrl
  import arb_xfer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              client0,
  input  logic              client1,
  input  logic              client2,
  input  logic              client3,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  arb_xfer_ctrl_if.master   bus,
  output logic              done0,
  output logic              done1,
  output logic              done2,
  output logic              done3,
  output logic              busy,
  output logic              err
);
  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);
  logic [DATA_W-1:0] data_a [NUM_CLIENTS];
  client_id_t enc_id;
  logic enc_valid, enc_multi;
  state_t state_q, state_d;
  client_id_t id_q, id_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d, err_q, err_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  assign data_a[0] = data0;
  assign data_a[1] = data1;
  assign data_a[2] = data2;
  assign data_a[3] = data3;
  onehot_enc u_enc (
    .grant({client3, client2, client1, client0}),
    .id(enc_id),
    .valid(enc_valid),
    .multi(enc_multi)
  );
  // next-state: grants are only looked at in IDLE, so a latched burst always runs to completion
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    cnt_d = cnt_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    err_d = err_q;
    done_d = '0;
    if (state_q == IDLE) begin
      err_d = err_q | enc_multi;
      if (enc_valid) begin
        state_d = XFER;
        id_d = enc_id;
        cnt_d = '0;
        data_d = data_a[enc_id];
        valid_d = 1'b1;
        last_d = LAST == 4'd0;
      end
    end else if (state_q == XFER) begin
      if (bus.out_ready && last_q) begin
        state_d = DONE;
        valid_d = 1'b0;
        last_d = 1'b0;
        done_d[id_q] = 1'b1;
      end else if (bus.out_ready) begin
        cnt_d = cnt_q + 4'd1;
        data_d = data_a[id_q];
        last_d = (cnt_q + 4'd1) == LAST;
      end
    end else begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  // all state and outputs registered; rst discards any burst in flight without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
`ifdef ARB_XFER_PARITY_EN
  logic par_q;
  // parity tracks out_data so it changes on exactly the same edges
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else par_q <= ^data_d;
  end
  assign bus.out_par = par_q;
`endif
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_id = id_q;
  assign bus.out_last = last_q;
  assign {done3, done2, done1, done0} = done_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule
